// File: rtl/ahb_fir_subordinate_n_if.sv
// AHB-Lite bus bundle for the FIR subordinate: address/control/write data
// from the manager, read data and response back from the subordinate.
interface ahb_fir_subordinate_n_if;
    logic        hsel;
    logic [4:0]  haddr;
    logic        hsize;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [15:0] hwdata;
    logic [15:0] hrdata;
    logic        hresp;
    logic        hready;

    modport master (
        output hsel, haddr, hsize, htrans, hwrite, hwdata,
        input  hrdata, hresp, hready
    );

    modport slave (
        input  hsel, haddr, hsize, htrans, hwrite, hwdata,
        output hrdata, hresp, hready
    );
endinterface

// File: rtl/ahb_fir_subordinate_n.sv
// AHB-Lite register front end for a FIR engine: sample FIFO, coefficient bank,
// status/control registers and two-cycle ERROR responses.
module ahb_fir_subordinate_n #(
    parameter int NUM_COEFF  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         n_rst,
    ahb_fir_subordinate_n_if.slave       bus,
    output logic [15:0]                  sample_data,
    output logic                         data_ready,
    input  logic                         sample_ack,
    input  logic                         modwait,
    input  logic                         err,
    input  logic [15:0]                  fir_out,
    output logic                         new_coefficient_set,
    input  logic                         clear_coeff,
    input  logic [$clog2(NUM_COEFF)-1:0] coefficient_num,
    output logic [15:0]                  fir_coefficient
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [15:0]   coeff_q [NUM_COEFF];
    logic [15:0]   coeff_d [NUM_COEFF];
    logic [15:0]   mem_q   [FIFO_DEPTH];
    logic [15:0]   mem_d   [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ncs_q, ncs_d;
    logic          wr_pend_q, wr_pend_d;
    logic [4:0]    wr_addr_q, wr_addr_d;
    logic          wr_size_q, wr_size_d;
    logic [15:0]   hrdata_q, hrdata_d;
    logic          hresp_q, hresp_d, hready_q, hready_d;

    logic          push, pop, full_ap, active, bad;
    logic          is_coeff, is_ro, is_wo, mapped;
    logic [15:0]   rdata;

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wdata,
                                          input logic odd, input logic half);
        if (half) return wdata;
        return odd ? {wdata[15:8], old[7:0]} : {old[15:8], wdata[7:0]};
    endfunction

    function automatic logic [15:0] lane(input logic [15:0] v, input logic odd, input logic half);
        if (half) return v;
        return odd ? {v[15:8], 8'h00} : {8'h00, v[7:0]};
    endfunction

    assign data_ready          = (count_q != '0);
    assign sample_data         = data_ready ? mem_q[rptr_q] : '0;
    assign new_coefficient_set = ncs_q;
    assign bus.hrdata          = hrdata_q;
    assign bus.hresp           = hresp_q;
    assign bus.hready          = hready_q;

    always_comb begin
        fir_coefficient = '0;
        for (int k = 0; k < NUM_COEFF; k++)
            if (int'(coefficient_num) == k) fir_coefficient = coeff_q[k];
    end

    // Data phase: commit the pending write with this cycle's hwdata, run the FIFO.
    always_comb begin
        coeff_d = coeff_q;
        mem_d   = mem_q;
        ncs_d   = ncs_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        push    = wr_pend_q && (wr_addr_q[4:1] == 4'd2);
        pop     = data_ready && sample_ack;
        if (clear_coeff) ncs_d = 1'b0;
        // Only a write that reaches the low byte can touch bit0, and it beats clear_coeff.
        if (wr_pend_q && (wr_addr_q[4:1] == 4'd4) && (wr_size_q || !wr_addr_q[0]))
            ncs_d = bus.hwdata[0];
        for (int k = 0; k < NUM_COEFF; k++)
            if (wr_pend_q && wr_addr_q[4] && (int'(wr_addr_q[3:1]) == k))
                coeff_d[k] = merge(coeff_q[k], bus.hwdata, wr_addr_q[0], wr_size_q);
        if (push) begin
            mem_d[wptr_q] = bus.hwdata;
            wptr_d        = wptr_q + PW'(1);
        end
        if (pop) rptr_d = rptr_q + PW'(1);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Address phase: decode, pick the error/OK response, register read data.
    always_comb begin
        active   = bus.hsel && (bus.htrans inside {2'b10, 2'b11}) && hready_q;
        is_coeff = bus.haddr[4] && (int'(bus.haddr[3:1]) < NUM_COEFF);
        is_ro    = !bus.haddr[4] && (bus.haddr[3:1] inside {3'd0, 3'd1, 3'd3});
        is_wo    = !bus.haddr[4] && (bus.haddr[3:1] == 3'd2);
        mapped   = is_coeff || (!bus.haddr[4] && (bus.haddr[3:1] <= 3'd4));
        full_ap  = (count_q + CW'(push)) == CW'(FIFO_DEPTH);
        bad      = !mapped
                || (bus.hsize && bus.haddr[0])
                || (bus.hwrite && is_ro)
                || (is_wo && (!bus.hwrite || !bus.hsize || full_ap))
                || (bus.hwrite && is_coeff && ncs_d);

        // RW registers read their next-state value so a write in its data phase forwards.
        rdata = '0;
        if (bus.haddr[4]) begin
            for (int k = 0; k < NUM_COEFF; k++)
                if (int'(bus.haddr[3:1]) == k) rdata = coeff_d[k];
        end else begin
            case (bus.haddr[3:1])
                3'd0:    rdata = {7'b0, err, 5'b0, count_q == '0, count_q == CW'(FIFO_DEPTH),
                                  modwait || ncs_q || data_ready};
                3'd1:    rdata = fir_out;
                3'd3:    rdata = 16'(count_q);
                3'd4:    rdata = {15'b0, ncs_d};
                default: rdata = '0;
            endcase
        end

        wr_pend_d = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_size_d = wr_size_q;
        hrdata_d  = '0;
        if (hresp_q && !hready_q)  {hresp_d, hready_d} = 2'b11;
        else if (active && bad)    {hresp_d, hready_d} = 2'b10;
        else                       {hresp_d, hready_d} = 2'b01;
        if (active && !bad) begin
            if (bus.hwrite) begin
                wr_pend_d = 1'b1;
                wr_addr_d = bus.haddr;
                wr_size_d = bus.hsize;
            end else begin
                hrdata_d = lane(rdata, bus.haddr[0], bus.hsize);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            coeff_q   <= '{default: '0};
            ncs_q     <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
            wr_size_q <= 1'b0;
            hrdata_q  <= '0;
            hresp_q   <= 1'b0;
            hready_q  <= 1'b1;
        end else begin
            coeff_q   <= coeff_d;
            ncs_q     <= ncs_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            wr_pend_q <= wr_pend_d;
            wr_addr_q <= wr_addr_d;
            wr_size_q <= wr_size_d;
            hrdata_q  <= hrdata_d;
            hresp_q   <= hresp_d;
            hready_q  <= hready_d;
        end
    end

    // FIFO storage is never read while empty, so it carries no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_ahb_fir_subordinate_n.sv
// Bench for ahb_fir_subordinate_n: directed vector table, hand sequences for
// FIFO/coefficient/reset corners, and randomized traffic against a queue model.
`timescale 1ns/1ps
module tb_ahb_fir_subordinate_n;
    localparam int NC = 4;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [15:0] sample_data, fir_out, fir_coefficient;
    logic        data_ready, sample_ack, modwait, err, new_coefficient_set, clear_coeff;
    logic [1:0]  coefficient_num;

    always #5 clk = ~clk;

    ahb_fir_subordinate_n_if bus_if();

    ahb_fir_subordinate_n #(.NUM_COEFF(NC), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .n_rst(n_rst), .bus(bus_if.slave),
        .sample_data(sample_data), .data_ready(data_ready), .sample_ack(sample_ack),
        .modwait(modwait), .err(err), .fir_out(fir_out),
        .new_coefficient_set(new_coefficient_set), .clear_coeff(clear_coeff),
        .coefficient_num(coefficient_num), .fir_coefficient(fir_coefficient)
    );

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic        sz;
        logic [15:0] wd;
        logic        e;
        logic [15:0] rd;
    } vec_t;

    vec_t vt[21];
    int   nvec = 0;
    int   nfail = 0;

    // Reference model state
    logic [15:0] q_m[$];
    logic [15:0] coef_m[NC];
    logic        ncs_m;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Entered and left on a negedge; the next call's address phase overlaps this data phase.
    task automatic xfer(input logic wr, input logic [4:0] a, input logic sz, input logic [15:0] wd,
                        output logic e, output logic [15:0] rd);
        bus_if.hsel   = 1'b1;
        bus_if.haddr  = a;
        bus_if.hsize  = sz;
        bus_if.htrans = 2'b10;
        bus_if.hwrite = wr;
        @(posedge clk);
        @(negedge clk);
        bus_if.hsel   = 1'b0;
        bus_if.htrans = 2'b00;
        bus_if.hwdata = wd;
        rd = bus_if.hrdata;
        e  = bus_if.hresp;
        if (e) begin
            chk("err_cycle1_hready", bus_if.hready, 1'b0);
            @(negedge clk);
            chk("err_cycle2_resp_ready", {bus_if.hresp, bus_if.hready}, 2'b11);
        end
    endtask

    function automatic logic [15:0] mmerge(input logic [15:0] old, input logic [15:0] wd,
                                           input logic odd, input logic sz);
        if (sz) return wd;
        if (odd) return {wd[15:8], old[7:0]};
        return {old[15:8], wd[7:0]};
    endfunction

    function automatic logic model_err(input logic wr, input logic [4:0] a, input logic sz);
        int  h = int'(a) & ~1;
        logic coef = (h >= 16) && (h < 16 + 2 * NC);
        logic ro   = (h == 0) || (h == 2) || (h == 6);
        if (!(ro || h == 4 || h == 8 || coef)) return 1'b1;
        if (sz && a[0]) return 1'b1;
        if (wr && ro) return 1'b1;
        if (h == 4 && (!wr || !sz || q_m.size() == FD)) return 1'b1;
        if (wr && coef && ncs_m) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] model_rd(input logic [4:0] a, input logic sz);
        int h = int'(a) & ~1;
        int n = q_m.size();
        logic [15:0] v = '0;
        if (h == 0)       v = {7'b0, err, 5'b0, n == 0, n == FD, modwait | ncs_m | (n != 0)};
        else if (h == 2)  v = fir_out;
        else if (h == 6)  v = 16'(n);
        else if (h == 8)  v = {15'b0, ncs_m};
        else if (h >= 16) v = coef_m[(h - 16) / 2];
        if (sz) return v;
        return a[0] ? {v[15:8], 8'h00} : {8'h00, v[7:0]};
    endfunction

    task automatic model_wr(input logic [4:0] a, input logic sz, input logic [15:0] wd);
        int h = int'(a) & ~1;
        if (h == 4) q_m.push_back(wd);
        else if (h == 8) begin
            if (sz || !a[0]) ncs_m = wd[0];
        end else coef_m[(h - 16) / 2] = mmerge(coef_m[(h - 16) / 2], wd, a[0], sz);
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        bus_if.hsel = 1'b0; bus_if.htrans = 2'b00;
        repeat (2) @(negedge clk);
        chk("rst_hready", bus_if.hready, 1'b1);
        chk("rst_hresp", bus_if.hresp, 1'b0);
        chk("rst_hrdata", bus_if.hrdata, 16'h0);
        chk("rst_data_ready", data_ready, 1'b0);
        chk("rst_sample_data", sample_data, 16'h0);
        chk("rst_ncs", new_coefficient_set, 1'b0);
        chk("rst_fir_coeff", fir_coefficient, 16'h0);
        n_rst = 1'b1;
        @(negedge clk);
        q_m.delete();
        coef_m = '{default: '0};
        ncs_m = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        e, wr, sz, exp_e;
        logic [15:0] rd, wd;
        logic [4:0]  a;
        int          r, nops;

        vt[0]  = '{1'b0, 5'h00, 1'b1, 16'h0000, 1'b0, 16'h0004};
        vt[1]  = '{1'b0, 5'h02, 1'b1, 16'h0000, 1'b0, 16'hC0DE};
        vt[2]  = '{1'b0, 5'h06, 1'b1, 16'h0000, 1'b0, 16'h0000};
        vt[3]  = '{1'b1, 5'h12, 1'b1, 16'hABCD, 1'b0, 16'h0000};
        vt[4]  = '{1'b0, 5'h12, 1'b1, 16'h0000, 1'b0, 16'hABCD};
        vt[5]  = '{1'b1, 5'h13, 1'b0, 16'hEEEE, 1'b0, 16'h0000};
        vt[6]  = '{1'b0, 5'h12, 1'b1, 16'h0000, 1'b0, 16'hEECD};
        vt[7]  = '{1'b0, 5'h13, 1'b0, 16'h0000, 1'b0, 16'hEE00};
        vt[8]  = '{1'b0, 5'h12, 1'b0, 16'h0000, 1'b0, 16'h00CD};
        vt[9]  = '{1'b0, 5'h1F, 1'b0, 16'h0000, 1'b1, 16'h0000};
        vt[10] = '{1'b1, 5'h00, 1'b1, 16'h5555, 1'b1, 16'h0000};
        vt[11] = '{1'b0, 5'h04, 1'b1, 16'h0000, 1'b1, 16'h0000};
        vt[12] = '{1'b0, 5'h03, 1'b1, 16'h0000, 1'b1, 16'h0000};
        vt[13] = '{1'b1, 5'h04, 1'b0, 16'h7777, 1'b1, 16'h0000};
        vt[14] = '{1'b0, 5'h0A, 1'b1, 16'h0000, 1'b1, 16'h0000};
        vt[15] = '{1'b0, 5'h12, 1'b1, 16'h0000, 1'b0, 16'hEECD};
        vt[16] = '{1'b1, 5'h08, 1'b1, 16'h0001, 1'b0, 16'h0000};
        vt[17] = '{1'b1, 5'h10, 1'b1, 16'h1111, 1'b1, 16'h0000};
        vt[18] = '{1'b0, 5'h10, 1'b1, 16'h0000, 1'b0, 16'h0000};
        vt[19] = '{1'b0, 5'h08, 1'b1, 16'h0000, 1'b0, 16'h0001};
        vt[20] = '{1'b0, 5'h00, 1'b1, 16'h0000, 1'b0, 16'h0005};

        bus_if.hsel = 1'b0; bus_if.haddr = '0; bus_if.hsize = 1'b1;
        bus_if.htrans = 2'b00; bus_if.hwrite = 1'b0; bus_if.hwdata = '0;
        sample_ack = 1'b0; modwait = 1'b0; err = 1'b0; fir_out = 16'hC0DE;
        clear_coeff = 1'b0; coefficient_num = 2'd0;
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 21; i++) begin
            xfer(vt[i].wr, vt[i].addr, vt[i].sz, vt[i].wd, e, rd);
            chk($sformatf("vec%0d_err", i), e, vt[i].e);
            if (!vt[i].wr && !vt[i].e) chk($sformatf("vec%0d_rdata", i), rd, vt[i].rd);
        end
        coefficient_num = 2'd1;
        #1 chk("fir_coeff_1", fir_coefficient, 16'hEECD);
        chk("ncs_set", new_coefficient_set, 1'b1);

        // clear_coeff, then status busy tracks modwait alone
        clear_coeff = 1'b1;
        cycle();
        clear_coeff = 1'b0;
        chk("ncs_cleared", new_coefficient_set, 1'b0);
        modwait = 1'b1;
        xfer(1'b0, 5'h00, 1'b1, 16'h0, e, rd);
        chk("status_modwait1", rd, 16'h0005);
        modwait = 1'b0;
        xfer(1'b0, 5'h00, 1'b1, 16'h0, e, rd);
        chk("status_modwait0", rd, 16'h0004);
        xfer(1'b1, 5'h10, 1'b1, 16'h1357, e, rd);
        chk("coef0_wr_ok", e, 1'b0);
        xfer(1'b0, 5'h10, 1'b1, 16'h0, e, rd);
        chk("coef0_rd", rd, 16'h1357);

        // two pushes, one pop
        xfer(1'b1, 5'h04, 1'b1, 16'h1234, e, rd);
        xfer(1'b1, 5'h04, 1'b1, 16'h5678, e, rd);
        cycle();
        chk("push_data_ready", data_ready, 1'b1);
        chk("push_head0", sample_data, 16'h1234);
        sample_ack = 1'b1;
        cycle();
        sample_ack = 1'b0;
        chk("pop_head1", sample_data, 16'h5678);
        xfer(1'b0, 5'h06, 1'b1, 16'h0, e, rd);
        chk("count_after_pop", rd, 16'd1);
        sample_ack = 1'b1;
        cycle();
        sample_ack = 1'b0;
        chk("drained_ready", data_ready, 1'b0);

        // overfill by one
        for (int i = 0; i < 5; i++) begin
            xfer(1'b1, 5'h04, 1'b1, 16'hA000 + 16'(i), e, rd);
            chk($sformatf("fill%0d_err", i), e, (i == 4));
        end
        xfer(1'b0, 5'h00, 1'b1, 16'h0, e, rd);
        chk("status_full", rd, 16'h0003);
        xfer(1'b0, 5'h06, 1'b1, 16'h0, e, rd);
        chk("count_full", rd, 16'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d", i), sample_data, 16'hA000 + 16'(i));
            sample_ack = 1'b1;
            cycle();
            sample_ack = 1'b0;
        end
        chk("drain_empty", data_ready, 1'b0);

        // reset during a push data phase
        bus_if.hsel = 1'b1; bus_if.haddr = 5'h04; bus_if.hsize = 1'b1;
        bus_if.htrans = 2'b10; bus_if.hwrite = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.hsel = 1'b0; bus_if.htrans = 2'b00; bus_if.hwdata = 16'h9999;
        n_rst = 1'b0;
        #1;
        chk("rstpush_hready", bus_if.hready, 1'b1);
        chk("rstpush_hresp", bus_if.hresp, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        cycle();
        chk("rstpush_data_ready", data_ready, 1'b0);
        chk("rstpush_hready_after", bus_if.hready, 1'b1);
        xfer(1'b0, 5'h06, 1'b1, 16'h0, e, rd);
        chk("rstpush_count", rd, 16'd0);

        // reset during error cycle 1
        bus_if.hsel = 1'b1; bus_if.haddr = 5'h04; bus_if.hsize = 1'b1;
        bus_if.htrans = 2'b10; bus_if.hwrite = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus_if.hsel = 1'b0; bus_if.htrans = 2'b00;
        chk("rsterr_c1", {bus_if.hresp, bus_if.hready}, 2'b10);
        n_rst = 1'b0;
        #1;
        chk("rsterr_resp_ready", {bus_if.hresp, bus_if.hready}, 2'b01);
        chk("rsterr_coeff_cleared", fir_coefficient, 16'h0);
        @(negedge clk);
        do_reset();

        // randomized traffic against the model
        for (int it = 0; it < 150; it++) begin
            fir_out = 16'($urandom);
            modwait = 1'($urandom);
            err     = 1'($urandom);
            nops    = $urandom_range(1, 5);
            for (int j = 0; j < nops; j++) begin
                r  = $urandom_range(0, 9);
                wd = 16'($urandom);
                if (r < 4) begin
                    wr = 1'b1; a = 5'h04; sz = 1'b1;
                end else if (r < 6) begin
                    wr = 1'($urandom); sz = 1'($urandom);
                    a  = 5'(16 + 2 * $urandom_range(0, NC - 1) + $urandom_range(0, 1));
                end else if (r == 6) begin
                    wr = 1'b1; sz = 1'($urandom); a = 5'(8 + $urandom_range(0, 1));
                end else begin
                    wr = 1'($urandom); sz = 1'($urandom); a = 5'($urandom);
                end
                if (!wr && (a[4:1] == 4'd0 || a[4:1] == 4'd3)) wr = 1'b1;
                exp_e = model_err(wr, a, sz);
                xfer(wr, a, sz, wd, e, rd);
                chk($sformatf("rnd%0d_%0d_err a=%0h w=%0b s=%0b", it, j, a, wr, sz), e, exp_e);
                if (!exp_e) begin
                    if (wr) model_wr(a, sz, wd);
                    else chk($sformatf("rnd%0d_%0d_rdata a=%0h", it, j, a), rd, model_rd(a, sz));
                end
            end
            cycle();
            chk($sformatf("rnd%0d_data_ready", it), data_ready, q_m.size() != 0);
            if (q_m.size() != 0) chk($sformatf("rnd%0d_sample", it), sample_data, q_m[0]);
            else chk($sformatf("rnd%0d_sample", it), sample_data, 16'h0);
            coefficient_num = 2'($urandom_range(0, 3));
            #1 chk($sformatf("rnd%0d_fir_coeff", it), fir_coefficient, coef_m[coefficient_num]);
            sample_ack  = 1'($urandom);
            clear_coeff = 1'($urandom);
            cycle();
            if (sample_ack && q_m.size() != 0) void'(q_m.pop_front());
            if (clear_coeff) ncs_m = 1'b0;
            sample_ack  = 1'b0;
            clear_coeff = 1'b0;
            chk($sformatf("rnd%0d_ncs", it), new_coefficient_set, ncs_m);
            xfer(1'b0, 5'h00, 1'b1, 16'h0, e, rd);
            chk($sformatf("rnd%0d_status", it), rd, model_rd(5'h00, 1'b1));
            xfer(1'b0, 5'h06, 1'b1, 16'h0, e, rd);
            chk($sformatf("rnd%0d_count", it), rd, model_rd(5'h06, 1'b1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
